jc_run_ctrl: RTL

JC_RUN_CTRL -- requirements
Module: jc_run_ctrl

---
 rtl/jc_ctrl_pkg.sv | 21 ++
 rtl/jc_core.sv | 37 +++
 rtl/jc_run_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/jc_ctrl_pkg.sv
// rtl/jc_ctrl_pkg.sv - shared types and defaults for the Johnson run controller
package jc_ctrl_pkg;

  localparam int JC_WIDTH_DEF  = 8;
  localparam int JC_STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } jc_state_e;

  // One bit indexes the two requesters.
  typedef logic req_idx_t;

  function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/jc_core.sv
// rtl/jc_core.sv - Johnson shift register with synchronous load and shift enable
module jc_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Load wins over shift; a shift feeds the inverted LSB into the MSB.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (en) begin
      q_d = {~q_q[0], q_q[WIDTH-1:1]};
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jc_run_ctrl.sv
// rtl/jc_run_ctrl.sv - two-requester round-robin controller for Johnson counter runs (option: JC_ILLEGAL_CHECK_EN)
module jc_run_ctrl
  import jc_ctrl_pkg::*;
#(
  parameter int WIDTH  = JC_WIDTH_DEF,
  parameter int STEP_W = JC_STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [WIDTH-1:0]  seed0,
  input  logic [WIDTH-1:0]  seed1,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [WIDTH-1:0]  result
`ifdef JC_ILLEGAL_CHECK_EN
  ,
  output logic              err
`endif
);

  jc_state_e         state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  req_idx_t          id_q, id_d;
  req_idx_t          prio_q, prio_d;
  logic [WIDTH-1:0]  seed_q, seed_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] rem_q, rem_d;

  req_idx_t          pick;
  logic              core_load;
  logic              core_en;
  logic              done_c;
  logic [WIDTH-1:0]  core_q;

  // Round-robin pick: a lone requester wins, a tie goes to the priority pointer.
  always_comb begin
    pick = prio_q;
    if (req == 2'b01) begin
      pick = 1'b0;
    end else if (req == 2'b10) begin
      pick = 1'b1;
    end
  end

  // Next-state and control decode; requests are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    prio_d    = prio_q;
    seed_d    = seed_q;
    steps_d   = steps_q;
    rem_d     = rem_q;
    core_load = 1'b0;
    core_en   = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          id_d    = pick;
          gnt_d   = idx_to_onehot(pick);
          seed_d  = pick ? seed1 : seed0;
          steps_d = pick ? steps1 : steps0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        core_load = 1'b1;
        rem_d     = steps_q;
        state_d   = (steps_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        core_en = 1'b1;
        rem_d   = rem_q - STEP_W'(1);
        if (rem_q == STEP_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        gnt_d   = 2'b00;
        prio_d  = ~id_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      seed_q  <= '0;
      steps_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      seed_q  <= seed_d;
      steps_q <= steps_d;
      rem_q   <= rem_d;
    end
  end

  jc_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .en   (core_en),
    .din  (seed_q),
    .q    (core_q)
  );

  assign gnt     = gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_c;
  assign done_id = id_q;
  assign result  = core_q;

`ifdef JC_ILLEGAL_CHECK_EN
  logic seed_legal;

  // A legal Johnson value has at most one bit boundary where adjacent bits differ.
  always_comb begin
    seed_legal = ($countones(seed_q[WIDTH-1:1] ^ seed_q[WIDTH-2:0]) <= 1);
  end

  assign err = done_c & ~seed_legal;
`endif

endmodule
